lsu_mem_access: RTL and testbench

- Load/store unit for the RV32I core. It consumes the operands the operand selector prepares.
- Takes the adder result as the effective address, rs2 as store data, and the 6-bit alucode (ALU_LB..ALU_SW).
- Runs a single-outstanding request/response transaction on the data-memory port.
- Returns a sign/zero-extended load result to writeback. Sits between execute and writeback; stalls the pipeline while busy.

---
 rtl/lsu_mem_access_pkg.sv | 46 ++++
 rtl/lsu_lane_align.sv | 49 ++++
 rtl/lsu_mem_access.sv | 154 +++++++++++++++
 tb/tb_lsu_mem_access.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_access_pkg.sv
// Shared LSU definitions: ALU op codes, LSU FSM states, op decode helpers.
// Imported by lsu_lane_align and lsu_mem_access.
package lsu_mem_access_pkg;

  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_SUB = 6'd1;
  localparam logic [5:0] ALU_LB  = 6'd18;
  localparam logic [5:0] ALU_LH  = 6'd19;
  localparam logic [5:0] ALU_LW  = 6'd20;
  localparam logic [5:0] ALU_LBU = 6'd21;
  localparam logic [5:0] ALU_LHU = 6'd22;
  localparam logic [5:0] ALU_SB  = 6'd23;
  localparam logic [5:0] ALU_SH  = 6'd24;
  localparam logic [5:0] ALU_SW  = 6'd25;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

  function automatic logic lsu_is_load(input logic [5:0] a);
    return (a == ALU_LB) || (a == ALU_LH) || (a == ALU_LW) ||
           (a == ALU_LBU) || (a == ALU_LHU);
  endfunction

  function automatic logic lsu_is_store(input logic [5:0] a);
    return (a == ALU_SB) || (a == ALU_SH) || (a == ALU_SW);
  endfunction

  function automatic logic lsu_is_mem(input logic [5:0] a);
    return lsu_is_load(a) || lsu_is_store(a);
  endfunction

  function automatic logic lsu_misaligned(
    input logic [5:0] a,
    input logic [1:0] lo
  );
    logic half;
    logic word;
    half = (a == ALU_LH) || (a == ALU_LHU) || (a == ALU_SH);
    word = (a == ALU_LW) || (a == ALU_SW);
    return (half && lo[0]) || (word && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store strobes/data replication and load extract+extend.
// Ports: i_alucode, i_addr_lo, i_store_data, i_rdata -> o_wstrb, o_wdata, o_ld_data.
module lsu_lane_align
  import lsu_mem_access_pkg::*;
(
  input  logic [5:0]  i_alucode,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword lane uses addr[1] only, so an unchecked odd address
  // still lands on a legal half.
  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_wstrb   = 4'b0000;
    o_wdata   = i_store_data;
    o_ld_data = i_rdata;
    unique case (1'b1)
      (i_alucode == ALU_SB): begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_store_data[7:0]}};
      end
      (i_alucode == ALU_SH): begin
        o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_store_data[15:0]}};
      end
      (i_alucode == ALU_SW): o_wstrb = 4'b1111;
      (i_alucode == ALU_LB):
        o_ld_data = {{24{w_byte[7]}}, w_byte};
      (i_alucode == ALU_LBU):
        o_ld_data = {24'd0, w_byte};
      (i_alucode == ALU_LH):
        o_ld_data = {{16{w_half[15]}}, w_half};
      (i_alucode == ALU_LHU):
        o_ld_data = {16'd0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// RV32I load/store unit: single-outstanding req/resp FSM with timeout.
// Ports: req_* from execute, mem_* data-memory port, wb_* to writeback,
// store_done/exc_misaligned/exc_bus pulses, busy. Macro: LSU_ALIGN_CHECK_EN.
module lsu_mem_access
  import lsu_mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        alucode,
  input  logic [31:0]       eff_addr,
  input  logic [31:0]       store_data,
  input  logic [4:0]        rd_num,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              store_done,
  output logic              exc_misaligned,
  output logic              exc_bus,
  output logic              busy
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e    r_state;
  logic [5:0]    r_alu;
  logic [31:0]   r_addr;
  logic [31:0]   r_sdata;
  logic [4:0]    r_rd;
  logic [CW-1:0] r_cnt;
  logic          r_wb_valid;
  logic [31:0]   r_wb_data;
  logic          r_store_done;
  logic          r_exc_mis;
  logic          r_exc_bus;

  logic          w_accept;
  logic          w_mis;
  logic          w_tout;
  logic [31:0]   w_ld_data;

  lsu_lane_align u_lane (
    .i_alucode    (r_alu),
    .i_addr_lo    (r_addr[1:0]),
    .i_store_data (r_sdata),
    .i_rdata      (mem_rdata),
    .o_wstrb      (mem_wstrb),
    .o_wdata      (mem_wdata),
    .o_ld_data    (w_ld_data)
  );

  assign w_accept = req_valid && (r_state == LSU_IDLE) &&
                    lsu_is_mem(alucode);

`ifdef LSU_ALIGN_CHECK_EN
  assign w_mis = lsu_misaligned(alucode, eff_addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  // Counter value TO_LAST marks the last allowed cycle in REQ/WAIT.
  assign w_tout = TO_EN && (r_cnt == TO_LAST);

  assign req_ready      = (r_state == LSU_IDLE);
  assign busy           = (r_state != LSU_IDLE);
  assign mem_req        = (r_state == LSU_REQ);
  assign mem_we         = lsu_is_store(r_alu);
  assign mem_addr       = ADDR_W'({r_addr[31:2], 2'b00});
  assign wb_valid       = r_wb_valid;
  assign wb_rd          = r_rd;
  assign wb_data        = r_wb_data;
  assign store_done     = r_store_done;
  assign exc_misaligned = r_exc_mis;
  assign exc_bus        = r_exc_bus;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= LSU_IDLE;
      r_alu        <= '0;
      r_addr       <= '0;
      r_sdata      <= '0;
      r_rd         <= '0;
      r_cnt        <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_data    <= '0;
      r_store_done <= 1'b0;
      r_exc_mis    <= 1'b0;
      r_exc_bus    <= 1'b0;
    end else begin
      r_wb_valid   <= 1'b0;
      r_store_done <= 1'b0;
      r_exc_mis    <= 1'b0;
      r_exc_bus    <= 1'b0;
      case (r_state)
        LSU_IDLE: begin
          if (w_accept) begin
            r_alu   <= alucode;
            r_addr  <= eff_addr;
            r_sdata <= store_data;
            r_rd    <= rd_num;
            r_cnt   <= '0;
            if (w_mis) r_exc_mis <= 1'b1;
            else       r_state   <= LSU_REQ;
          end
        end
        LSU_REQ: begin
          if (mem_ready) begin
            r_cnt <= '0;
            if (lsu_is_store(r_alu)) begin
              r_store_done <= 1'b1;
              r_state      <= LSU_IDLE;
            end else begin
              r_state <= LSU_WAIT;
            end
          end else if (w_tout) begin
            r_exc_bus <= 1'b1;
            r_state   <= LSU_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LSU_WAIT: begin
          if (mem_rvalid) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= w_ld_data;
            r_state    <= LSU_IDLE;
          end else if (w_tout) begin
            r_exc_bus <= 1'b1;
            r_state   <= LSU_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Scoreboard bench for lsu_mem_access: random + directed loads/stores.
// Expected events are queued by the driver and popped by a negedge monitor.
module tb_lsu_mem_access;
  import lsu_mem_access_pkg::*;

  localparam int TO = 4;
`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  alucode;
  logic [31:0] eff_addr;
  logic [31:0] store_data;
  logic [4:0]  rd_num;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        store_done;
  logic        exc_misaligned;
  logic        exc_bus;
  logic        busy;

  lsu_mem_access #(
    .TIMEOUT_CYCLES (TO),
    .ADDR_W         (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .alucode        (alucode),
    .eff_addr       (eff_addr),
    .store_data     (store_data),
    .rd_num         (rd_num),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wstrb      (mem_wstrb),
    .mem_wdata      (mem_wdata),
    .mem_ready      (mem_ready),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .store_done     (store_done),
    .exc_misaligned (exc_misaligned),
    .exc_bus        (exc_bus),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {E_MEM, E_WB, E_SD, E_MIS, E_BUS} ev_e;
  typedef struct {
    ev_e         kind;
    logic        we;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic int op_size(logic [5:0] alu);
    case (alu)
      ALU_LB, ALU_LBU, ALU_SB: return 1;
      ALU_LH, ALU_LHU, ALU_SH: return 2;
      default:                 return 4;
    endcase
  endfunction

  function automatic bit op_store(logic [5:0] alu);
    return alu inside {ALU_SB, ALU_SH, ALU_SW};
  endfunction

  function automatic bit op_signed(logic [5:0] alu);
    return alu inside {ALU_LB, ALU_LH};
  endfunction

  function automatic int lane_of(logic [31:0] addr, int sz);
    if (sz == 4) return 0;
    if (sz == 2) return int'(addr & 32'd2);
    return int'(addr & 32'd3);
  endfunction

  function automatic bit mis_of(logic [31:0] addr, int sz);
    return ALIGN_EN && ((addr % sz) != 0);
  endfunction

  function automatic logic [31:0] st_strb(logic [31:0] addr, int sz);
    return 32'(((1 << sz) - 1) << lane_of(addr, sz));
  endfunction

  function automatic logic [31:0] st_data(logic [31:0] d, int sz);
    if (sz == 1) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ld_val(logic [5:0] alu,
                                         logic [31:0] addr,
                                         logic [31:0] w);
    int     sz;
    longint v;
    longint full;
    sz = op_size(alu);
    v  = longint'(w) >> (8 * lane_of(addr, sz));
    if (sz < 4) begin
      full = longint'(1) << (8 * sz);
      v    = v % full;
      if (op_signed(alu) && v >= full / 2) v = v - full;
    end
    return v[31:0];
  endfunction

  // ---------------- monitor ----------------
  task automatic mon_pop(ev_e k);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event got=%0d want=none", int'(k));
    end else begin
      e = q.pop_front();
      chk("event_kind", 32'(k), 32'(e.kind));
      if (k == e.kind) begin
        if (k == E_MEM) begin
          chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
          chk("mem_addr", mem_addr, e.a);
          chk("mem_wstrb", {28'd0, mem_wstrb}, e.b);
          if (e.we) chk("mem_wdata", mem_wdata, e.c);
        end else if (k == E_WB) begin
          chk("wb_rd", {27'd0, wb_rd}, e.a);
          chk("wb_data", wb_data, e.b);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("wb_sd_exclusive", {31'd0, wb_valid & store_done}, 32'd0);
      if (mem_req && mem_ready) mon_pop(E_MEM);
      if (store_done)           mon_pop(E_SD);
      if (wb_valid)             mon_pop(E_WB);
      if (exc_misaligned)       mon_pop(E_MIS);
      if (exc_bus)              mon_pop(E_BUS);
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic present(logic [5:0] alu, logic [31:0] addr,
                         logic [31:0] d, logic [4:0] rd);
    req_valid  = 1'b1;
    alucode    = alu;
    eff_addr   = addr;
    store_data = d;
    rd_num     = rd;
  endtask

  task automatic unpresent();
    req_valid  = 1'b0;
    alucode    = 6'($urandom);
    eff_addr   = $urandom;
    store_data = $urandom;
    rd_num     = 5'($urandom);
  endtask

  task automatic run_op(logic [5:0] alu, logic [31:0] addr,
                        logic [31:0] d, logic [4:0] rd,
                        int dr, int dw, logic [31:0] rword);
    int sz;
    bit st;
    bit busy_ok;
    sz      = op_size(alu);
    st      = op_store(alu);
    busy_ok = 1'b1;
    wait_idle();
    present(alu, addr, d, rd);
    if (mis_of(addr, sz)) begin
      q.push_back('{kind: E_MIS, we: 1'b0, a: 0, b: 0, c: 0});
    end else begin
      q.push_back('{kind: E_MEM, we: st, a: addr & ~32'd3,
                    b: st ? st_strb(addr, sz) : 32'd0,
                    c: st_data(d, sz)});
      if (st)
        q.push_back('{kind: E_SD, we: 1'b0, a: 0, b: 0, c: 0});
      else
        q.push_back('{kind: E_WB, we: 1'b0, a: 32'(rd),
                      b: ld_val(alu, addr, rword), c: 0});
    end
    step();
    unpresent();
    if (mis_of(addr, sz)) begin
      chk("mis_pulse", {31'd0, exc_misaligned}, 32'd1);
      chk("mis_no_req", {31'd0, mem_req}, 32'd0);
      chk("mis_ready", {31'd0, req_ready}, 32'd1);
      return;
    end
    for (int i = 0; i < dr; i++) begin
      busy_ok    = busy_ok & busy;
      mem_rvalid = 1'($urandom);
      mem_rdata  = $urandom;
      step();
    end
    busy_ok    = busy_ok & busy;
    mem_ready  = 1'b1;
    mem_rvalid = 1'($urandom);
    step();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    if (st) begin
      chk("store_done_latency", {31'd0, store_done}, 32'd1);
    end else begin
      for (int i = 0; i < dw; i++) begin
        busy_ok = busy_ok & busy;
        step();
      end
      busy_ok    = busy_ok & busy;
      mem_rvalid = 1'b1;
      mem_rdata  = rword;
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      chk("wb_latency", {31'd0, wb_valid}, 32'd1);
    end
    chk("busy_during_op", {31'd0, busy_ok}, 32'd1);
  endtask

  task automatic run_nonmem(logic [5:0] alu);
    wait_idle();
    present(alu, $urandom, $urandom, 5'($urandom));
    mem_rvalid = 1'b1;
    step();
    unpresent();
    mem_rvalid = 1'b0;
    chk("nonmem_stays_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_store_done"}, {31'd0, store_done}, 32'd0);
    chk({tag, "_exc_mis"}, {31'd0, exc_misaligned}, 32'd0);
    chk({tag, "_exc_bus"}, {31'd0, exc_bus}, 32'd0);
  endtask

  logic [5:0] codes [10];

  initial begin
    int n;
    codes = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
              ALU_SB, ALU_SH, ALU_SW, ALU_ADD, ALU_SUB};
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    alucode    = '0;
    eff_addr   = '0;
    store_data = '0;
    rd_num     = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // directed cases
    run_op(ALU_SW, 32'h1000, 32'hDEADBEEF, 5'd3, 0, 0, 32'd0);
    run_op(ALU_LB, 32'h2003, 32'd0, 5'd7, 0, 2, 32'h80FF1234);
    run_op(ALU_LHU, 32'h2002, 32'd0, 5'd9, 0, 0, 32'h80FF1234);
    run_op(ALU_LH, 32'h2002, 32'd0, 5'd0, 1, 1, 32'h80FF1234);
    run_op(ALU_SB, 32'h5002, 32'h000000A5, 5'd1, 2, 0, 32'd0);
    run_op(ALU_SH, 32'h3001, 32'hCAFEBABE, 5'd2, 0, 0, 32'd0);
    run_op(ALU_LW, 32'h2003, 32'd0, 5'd4, 0, 0, 32'h01234567);
    run_nonmem(ALU_ADD);

    // timeout while REQ: mem_ready held low
    wait_idle();
    present(ALU_LW, 32'h4000, 32'd0, 5'd5);
    q.push_back('{kind: E_BUS, we: 1'b0, a: 0, b: 0, c: 0});
    step();
    unpresent();
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      step();
    end
    chk("timeout_req_cycles", 32'(n), 32'(TO));
    chk("timeout_req_bus", {31'd0, exc_bus}, 32'd1);
    chk("timeout_req_idle", {31'd0, req_ready}, 32'd1);

    // timeout while WAIT: no rvalid
    wait_idle();
    present(ALU_LW, 32'h4004, 32'd0, 5'd6);
    q.push_back('{kind: E_MEM, we: 1'b0, a: 32'h4004, b: 0, c: 0});
    q.push_back('{kind: E_BUS, we: 1'b0, a: 0, b: 0, c: 0});
    step();
    unpresent();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      step();
    end
    chk("timeout_wait_cycles", 32'(n), 32'(TO));
    chk("timeout_wait_bus", {31'd0, exc_bus}, 32'd1);

    // random traffic
    for (int i = 0; i < 150; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k >= 8)
        run_nonmem(codes[k]);
      else
        run_op(codes[k], $urandom, $urandom, 5'($urandom),
               $urandom_range(0, 2), $urandom_range(0, 2),
               $urandom);
    end

    // reset while WAIT abandons the load
    wait_idle();
    present(ALU_LB, 32'h6001, 32'd0, 5'd11);
    q.push_back('{kind: E_MEM, we: 1'b0, a: 32'h6000, b: 0, c: 0});
    step();
    unpresent();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h000000FF;
    step();
    mem_rvalid = 1'b0;
    chk("post_reset_no_wb", {31'd0, wb_valid}, 32'd0);
    repeat (3) step();

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
